seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Three-digit multiplexed hex display scanner with a one-deep pending write slot; SEG_SCAN_BLANK_EN adds leading-zero blanking.
// Latency: dig/blank/wr_ready are combinational; a write is displayed from the first frame boundary after its transfer.
// Backpressure: wr_ready drops while a value is pending and reopens only in the boundary cycle that consumes it.
module seg_scan_ctrl #(
   parameter int DWELL = 131072,
   parameter int CNT_W = 18
) (
   input  logic              clk_25mhz,
   input  logic              rst_n,
   input  logic              wr_valid,
   input  logic [11:0]       wr_data,
   output logic              wr_ready,
   output logic [2:0]        ca,
   output logic [3:0]        dig,
   output logic              blank,
   output logic              frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [2:0]       CA_D0    = 3'b110;
   localparam logic [2:0]       CA_D1    = 3'b101;
   localparam logic [2:0]       CA_D2    = 3'b011;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       ca_q, ca_d;
   logic [11:0]      disp_q, disp_d;
   logic [11:0]      pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic             frame_done_q, frame_done_d;

   logic last_dwell;
   logic boundary;
   logic xfer;

   assign last_dwell = (cnt_q == CNT_LAST);
   assign boundary   = last_dwell && (ca_q == CA_D2);
   assign xfer       = wr_valid && wr_ready;

   always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         ca_q         <= CA_D0;
         disp_q       <= '0;
         pend_q       <= '0;
         pend_v_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         ca_q         <= ca_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_v_q     <= pend_v_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      cnt_d        = last_dwell ? '0 : cnt_q + CNT_W'(1);
      ca_d         = last_dwell ? {ca_q[1:0], ca_q[2]} : ca_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_v_d     = pend_v_q | xfer;
      frame_done_d = boundary;
      // The display takes the old pending value before a same-cycle write replaces it.
      if (boundary) begin
         if (pend_v_q) disp_d = pend_q;
         pend_v_d = xfer;
      end
      if (xfer) pend_d = wr_data;
   end

   always_comb begin
      wr_ready   = !pend_v_q || boundary;
      ca         = ca_q;
      frame_done = frame_done_q;
      dig        = 4'h0;
      blank      = 1'b0;
      case (ca_q)
         CA_D0: dig = disp_q[3:0];
         CA_D1: begin
            dig = disp_q[7:4];
`ifdef SEG_SCAN_BLANK_EN
            blank = (disp_q[11:4] == 8'h00);
`endif
         end
         CA_D2: begin
            dig = disp_q[11:8];
`ifdef SEG_SCAN_BLANK_EN
            blank = (disp_q[11:8] == 4'h0);
`endif
         end
         default: begin
            dig   = 4'h0;
            blank = 1'b1;
         end
      endcase
   end

endmodule
